// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// ---------------------------------------------------------------------------
// Write side of an asynchronous FIFO. Four requesters share it through a
// round-robin arbiter. The block arbitrates requests and registers the memory
// write port. It keeps the binary/Gray write pointer, and it derives full,
// almost_full and the fill level from the synchronised Gray read pointer.
//
// Handshake: req[i]/gnt[i] is a request/acknowledge pair. A requester holds
// req[i] with its word on din[i*DATA_W +: DATA_W]. The word is taken in the
// cycle gnt[i]=1 (gnt is combinational from req, full and rr). The requester
// may then drop req[i] or present its next word. Nothing is accepted while
// full=1.
//
// Ports
//   clk          write-domain clock
//   rst_n        asynchronous active-low reset
//   req[3:0]     per-requester write request
//   din          four packed data words, requester i at [i*DATA_W +: DATA_W]
//   rd_ptr_sync  Gray read pointer, already synchronised into clk
//   gnt[3:0]     one-hot grant (combinational)
//   mem_we       registered memory write enable
//   mem_addr     registered memory write address
//   mem_wdata    registered memory write data
//   wr_ptr_gray  registered Gray write pointer for the read-domain synchroniser
//   full         registered full flag
//   almost_full  registered flag, level >= AFULL_TH
//   level        registered fill level, 0 .. 2^ADDR_W
//   stall_cnt    saturating count of cycles with requests but no grant
//
// ADDR_W must be at least 2. The full test inverts the two pointer MSBs.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8,
    parameter int AFULL_TH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   din,
    input  logic [ADDR_W:0]       rd_ptr_sync,
    output logic [3:0]            gnt,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [ADDR_W:0]       wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_W:0]       level,
    output logic [7:0]            stall_cnt
);

    localparam int PW = ADDR_W + 1;
    localparam logic [ADDR_W:0] AFULL_LVL = PW'(AFULL_TH);

    logic [ADDR_W:0]   wbin;
    logic [1:0]        rr;

    logic              accept;
    logic [1:0]        gnt_idx;
    logic [1:0]        cand;
    logic [DATA_W-1:0] wdata_sel;

    logic [ADDR_W:0]   wbin_next;
    logic [ADDR_W:0]   gray_next;
    logic [ADDR_W:0]   rbin;
    logic [ADDR_W:0]   rd_full_pat;
    logic [ADDR_W:0]   level_next;
    logic              full_next;
    logic              afull_next;

    // ------------------------------------------------------------------
    // Round-robin grant. Search starts at rr and wraps through all four
    // requesters. rst_n is in this path so that the grant drops as soon as
    // reset asserts, not at the next edge.
    // ------------------------------------------------------------------
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        accept  = 1'b0;
        cand    = '0;
        if (rst_n && !full && (req != 4'b0000)) begin
            for (int o = 0; o < 4; o++) begin
                cand = rr + 2'(o);
                if (!accept && req[cand]) begin
                    accept  = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        if (accept) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Data of the granted requester
    always_comb begin
        wdata_sel = '0;
        for (int i = 0; i < 4; i++) begin
            if (gnt_idx == 2'(i)) begin
                wdata_sel = din[i*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointer arithmetic. Flags and level come from the post-write pointer
    // and the current synchronised read pointer. A write and a read advance
    // in the same cycle therefore resolve correctly.
    // ------------------------------------------------------------------
    always_comb begin
        wbin_next = accept ? (wbin + PW'(1)) : wbin;
        gray_next = (wbin_next >> 1) ^ wbin_next;
    end

    // Gray-to-binary conversion: each binary bit is the XOR of all Gray bits
    // at and above it.
    always_comb begin
        rbin         = '0;
        rbin[ADDR_W] = rd_ptr_sync[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rd_ptr_sync[i];
        end
    end

    // The FIFO is full when the write pointer is exactly one lap ahead. In
    // Gray code that is the read pointer with its top two bits inverted.
    always_comb begin
        rd_full_pat = {~rd_ptr_sync[ADDR_W:ADDR_W-1], rd_ptr_sync[ADDR_W-2:0]};
        full_next   = (gray_next == rd_full_pat);
        level_next  = wbin_next - rbin;
        afull_next  = (level_next >= AFULL_LVL);
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin        <= '0;
            rr          <= '0;
            wr_ptr_gray <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            level       <= '0;
            stall_cnt   <= '0;
        end else begin
            wbin        <= wbin_next;
            wr_ptr_gray <= gray_next;
            full        <= full_next;
            almost_full <= afull_next;
            level       <= level_next;
            mem_we      <= accept;
            if (accept) begin
                mem_addr  <= wbin[ADDR_W-1:0];
                mem_wdata <= wdata_sel;
                rr        <= gnt_idx + 2'd1;
            end
            // A stall is any cycle with requests pending and no grant. The
            // counter sticks at its maximum.
            if ((req != 4'b0000) && !accept && (stall_cnt != 8'hFF)) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sanity properties
    // ------------------------------------------------------------------
    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt));
    a_no_gnt_full : assert property (@(posedge clk) disable iff (!rst_n)
        full |-> (gnt == 4'b0000));
    a_gray_step : assert property (@(posedge clk) disable iff (!rst_n)
        $countones(gray_next ^ wr_ptr_gray) <= 1);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter with default parameters
// (ADDR_W=3, DATA_W=8, AFULL_TH=6). Each scenario task drives its own
// stimulus and checks its own results against hand-derived values.
module tb_fifo_wr_arbiter;

    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 8;
    localparam int AFULL_TH = 6;

    logic                clk;
    logic                rst_n;
    logic [3:0]          req;
    logic [4*DATA_W-1:0] din;
    logic [ADDR_W:0]     rd_ptr_sync;
    logic [3:0]          gnt;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [ADDR_W:0]     wr_ptr_gray;
    logic                full;
    logic                almost_full;
    logic [ADDR_W:0]     level;
    logic [7:0]          stall_cnt;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] exp_q[$];

    fifo_wr_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .din         (din),
        .rd_ptr_sync (rd_ptr_sync),
        .gnt         (gnt),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .wr_ptr_gray (wr_ptr_gray),
        .full        (full),
        .almost_full (almost_full),
        .level       (level),
        .stall_cnt   (stall_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Drives reset for two edges and releases it on a falling edge.
    task automatic apply_reset();
        rst_n       = 1'b0;
        req         = 4'b0000;
        din         = '0;
        rd_ptr_sync = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n       = 1'b0;
        req         = 4'b1111;
        din         = 32'($urandom());
        rd_ptr_sync = '0;
        @(negedge clk);
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 3'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 00", mem_wdata); end
        checks++; if (wr_ptr_gray !== 4'b0000) begin errors++; $display("FAIL reset_wr_ptr_gray: got %b expected 0000", wr_ptr_gray); end
        checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL reset_flags: got full=%b afull=%b expected 0 0", full, almost_full); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    endtask

    // All four requesting from empty. Expected: grants 0,1,2,3,0,1,2,3 and then full.
    task automatic test_fill_sequence();
        int exp_k;
        logic [DATA_W-1:0] exp_d;
        apply_reset();
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            din   = 32'($urandom());
            exp_k = c % 4;
            #1;
            checks++; if (gnt !== 4'(1 << exp_k)) begin errors++; $display("FAIL fill_gnt[%0d]: got %b expected %b", c, gnt, 4'(1 << exp_k)); end
            exp_q.push_back(din[exp_k*DATA_W +: DATA_W]);
            @(posedge clk);
            #1;
            exp_d = exp_q.pop_front();
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL fill_mem_we[%0d]: got %b expected 1", c, mem_we); end
            checks++; if (mem_addr !== 3'(c)) begin errors++; $display("FAIL fill_mem_addr[%0d]: got %0d expected %0d", c, mem_addr, c); end
            checks++; if (mem_wdata !== exp_d) begin errors++; $display("FAIL fill_mem_wdata[%0d]: got %h expected %h", c, mem_wdata, exp_d); end
            checks++; if (wr_ptr_gray !== gray4(4'(c + 1))) begin errors++; $display("FAIL fill_wr_ptr_gray[%0d]: got %b expected %b", c, wr_ptr_gray, gray4(4'(c + 1))); end
            checks++; if (level !== 4'(c + 1)) begin errors++; $display("FAIL fill_level[%0d]: got %0d expected %0d", c, level, c + 1); end
            checks++; if (full !== (c == 7)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", c, full, (c == 7)); end
            checks++; if (almost_full !== ((c + 1) >= AFULL_TH)) begin errors++; $display("FAIL fill_afull[%0d]: got %b expected %b", c, almost_full, ((c + 1) >= AFULL_TH)); end
            @(negedge clk);
        end
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL full_gnt: got %b expected 0000", gnt); end
        checks++; if (full !== 1'b1 || level !== 4'd8) begin errors++; $display("FAIL full_state: got full=%b level=%0d expected 1 8", full, level); end
        checks++; if (wr_ptr_gray !== 4'b1100) begin errors++; $display("FAIL full_wr_ptr_gray: got %b expected 1100", wr_ptr_gray); end
        @(posedge clk);
        #1;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 3'd7) begin errors++; $display("FAIL full_hold: got we=%b addr=%0d expected 0 7", mem_we, mem_addr); end
        checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL full_stall_cnt: got %0d expected 1", stall_cnt); end
    endtask

    // Starting full: one read slot frees up, one grant goes through, full returns.
    task automatic test_full_release();
        @(negedge clk);
        rd_ptr_sync = 4'b0001;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL release_gnt_pre: got %b expected 0000", gnt); end
        @(posedge clk);
        #1;
        checks++; if (full !== 1'b0 || level !== 4'd7) begin errors++; $display("FAIL release_open: got full=%b level=%0d expected 0 7", full, level); end
        checks++; if (stall_cnt !== 8'd2) begin errors++; $display("FAIL release_stall_cnt: got %0d expected 2", stall_cnt); end
        @(negedge clk);
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL release_gnt: got %b expected 0001", gnt); end
        @(posedge clk);
        #1;
        checks++; if (full !== 1'b1 || level !== 4'd8) begin errors++; $display("FAIL release_refull: got full=%b level=%0d expected 1 8", full, level); end
        checks++; if (mem_we !== 1'b1 || mem_addr !== 3'd0) begin errors++; $display("FAIL release_write: got we=%b addr=%0d expected 1 0", mem_we, mem_addr); end
        checks++; if (wr_ptr_gray !== 4'b1101) begin errors++; $display("FAIL release_wr_ptr_gray: got %b expected 1101", wr_ptr_gray); end
        checks++; if (stall_cnt !== 8'd2) begin errors++; $display("FAIL release_stall_hold: got %0d expected 2", stall_cnt); end
    endtask

    // Stay full with requests pending. Expected: stall_cnt climbs and sticks at 255.
    task automatic test_stall_saturation();
        @(negedge clk);
        req = 4'b1111;
        repeat (100) @(posedge clk);
        #1;
        checks++; if (stall_cnt !== 8'd102) begin errors++; $display("FAIL stall_mid: got %0d expected 102", stall_cnt); end
        repeat (200) @(posedge clk);
        #1;
        checks++; if (stall_cnt !== 8'd255) begin errors++; $display("FAIL stall_sat: got %0d expected 255", stall_cnt); end
        checks++; if (wr_ptr_gray !== 4'b1101 || level !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL stall_ptr_hold: got gray=%b level=%0d full=%b expected 1101 8 1", wr_ptr_gray, level, full); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL stall_mem_we: got %b expected 0", mem_we); end
    endtask

    // Requesters 0 and 2 held. Expected: grants 0001, 0100, 0001.
    task automatic test_round_robin_pattern();
        logic [3:0] exp_g [3];
        int         exp_i [3];
        logic [DATA_W-1:0] exp_d;
        exp_g = '{4'b0001, 4'b0100, 4'b0001};
        exp_i = '{0, 2, 0};
        apply_reset();
        // With no requests there is no grant and no stall.
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt: got %b expected 0000", gnt); end
        @(posedge clk);
        #1;
        checks++; if (stall_cnt !== 8'd0 || mem_we !== 1'b0) begin errors++; $display("FAIL idle_state: got stall=%0d we=%b expected 0 0", stall_cnt, mem_we); end
        @(negedge clk);
        req = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            din = 32'($urandom());
            #1;
            checks++; if (gnt !== exp_g[c]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt, exp_g[c]); end
            exp_q.push_back(din[exp_i[c]*DATA_W +: DATA_W]);
            @(posedge clk);
            #1;
            exp_d = exp_q.pop_front();
            checks++; if (mem_we !== 1'b1 || mem_wdata !== exp_d) begin errors++; $display("FAIL rr_wdata[%0d]: got we=%b data=%h expected 1 %h", c, mem_we, mem_wdata, exp_d); end
            @(negedge clk);
        end
        req = 4'b0000;
    endtask

    // 16 writes from requester 1, with the read pointer keeping pace.
    // Expected: the address wraps and full never asserts.
    task automatic test_wrap_matching_reads();
        logic [3:0] prev_gray;
        apply_reset();
        req       = 4'b0010;
        prev_gray = 4'b0000;
        for (int c = 0; c < 16; c++) begin
            rd_ptr_sync = gray4(4'(c));
            din         = 32'($urandom());
            #1;
            checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wrap_gnt[%0d]: got %b expected 0010", c, gnt); end
            @(posedge clk);
            #1;
            checks++; if (mem_addr !== 3'(c % 8)) begin errors++; $display("FAIL wrap_mem_addr[%0d]: got %0d expected %0d", c, mem_addr, c % 8); end
            checks++; if (wr_ptr_gray !== gray4(4'(c + 1))) begin errors++; $display("FAIL wrap_wr_ptr_gray[%0d]: got %b expected %b", c, wr_ptr_gray, gray4(4'(c + 1))); end
            checks++; if ($countones(wr_ptr_gray ^ prev_gray) != 1) begin errors++; $display("FAIL wrap_gray_step[%0d]: got %b after %b expected one bit change", c, wr_ptr_gray, prev_gray); end
            checks++; if (full !== 1'b0 || level !== 4'd1) begin errors++; $display("FAIL wrap_flags[%0d]: got full=%b level=%0d expected 0 1", c, full, level); end
            prev_gray = wr_ptr_gray;
            @(negedge clk);
        end
        req = 4'b0000;
    endtask

    // Reset pulse at level 5 in the middle of a burst.
    task automatic test_midburst_reset();
        apply_reset();
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            din = 32'($urandom());
            @(posedge clk);
            #1;
            if (c < 4) @(negedge clk);
        end
        checks++; if (level !== 4'd5) begin errors++; $display("FAIL midrst_level_pre: got %0d expected 5", level); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000 || mem_we !== 1'b0) begin errors++; $display("FAIL midrst_gnt_we: got gnt=%b we=%b expected 0000 0", gnt, mem_we); end
        checks++; if (level !== 4'd0 || wr_ptr_gray !== 4'd0 || mem_addr !== 3'd0 || mem_wdata !== 8'd0) begin errors++; $display("FAIL midrst_regs: got level=%0d gray=%b addr=%0d data=%h expected 0", level, wr_ptr_gray, mem_addr, mem_wdata); end
        checks++; if (full !== 1'b0 || almost_full !== 1'b0 || stall_cnt !== 8'd0) begin errors++; $display("FAIL midrst_flags: got full=%b afull=%b stall=%0d expected 0 0 0", full, almost_full, stall_cnt); end
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_release_we: got %b expected 0", mem_we); end
        @(posedge clk);
        #1;
        checks++; if (mem_we !== 1'b0 || level !== 4'd0 || wr_ptr_gray !== 4'd0) begin errors++; $display("FAIL midrst_after: got we=%b level=%0d gray=%b expected 0 0 0000", mem_we, level, wr_ptr_gray); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_fill_sequence();
        test_full_release();
        test_stall_saturation();
        test_round_robin_pattern();
        test_wrap_matching_reads();
        test_midburst_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, meaning FIFO depth is 2^ADDR_W entries and pointers are ADDR_W+1 bits.
REQ-002 SHALL have parameter DATA_W, default 8, meaning the width of each requester data word.
REQ-003 SHALL have parameter AFULL_TH, default 6, meaning the fill level at or above which almost_full asserts.
REQ-004 SHALL have port clk, input, 1 bit: the write-domain clock.
REQ-005 SHALL have port rst_n, input, 1 bit: the reset, asynchronous, active-low.
REQ-006 SHALL have port req, input, 4 bits: per-requester write request.
REQ-007 SHALL have port din, input, 4*DATA_W bits: requester i data on bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port rd_ptr_sync, input, ADDR_W+1 bits: Gray read pointer, already two-flop synchronised into clk.
REQ-009 SHALL have port gnt, output, 4 bits: one-hot grant (combinational); the write is accepted in the cycle gnt[i]=1.
REQ-010 SHALL have port mem_we, output, 1 bit: registered memory write enable.
REQ-011 SHALL have port mem_addr, output, ADDR_W bits: registered write address.
REQ-012 SHALL have port mem_wdata, output, DATA_W bits: registered write data.
REQ-013 SHALL have port wr_ptr_gray, output, ADDR_W+1 bits: registered Gray write pointer, sent to the read-domain synchroniser.
REQ-014 SHALL have ports full and almost_full, output, 1 bit each, both registered.
REQ-015 SHALL have port level, output, ADDR_W+1 bits: registered fill level, 0..2^ADDR_W.
REQ-016 SHALL have port stall_cnt, output, 8 bits: saturating count of cycles in which req was nonzero but no grant issued.

Function
REQ-017 SHALL keep a binary write pointer wbin (ADDR_W+1 bits) and a round-robin priority pointer rr (2 bits).
REQ-018 SHALL, when full=0 and req!=0, grant the first requester with req=1 searching rr, rr+1, rr+2, rr+3 (mod 4).
REQ-019 SHALL drive gnt=0 whenever full=1 or req=0.
REQ-020 SHALL, on an accepted write by requester k, set rr to (k+1) mod 4 at the clock edge; otherwise rr SHALL hold.
REQ-021 SHALL, on an accepted write, register the following at the same edge: mem_we=1, mem_addr=wbin[ADDR_W-1:0], mem_wdata=din of requester k. wbin SHALL increment by 1, wrapping modulo 2^(ADDR_W+1).
REQ-022 SHALL register mem_we=0 in cycles with no accepted write; mem_addr and mem_wdata SHALL then hold.
REQ-023 SHALL register wr_ptr_gray as the Gray code of the next wbin, i.e. (wbin_next>>1)^wbin_next, so only one bit changes per write.
REQ-024 SHALL register full=1 when wr_ptr_gray_next equals rd_ptr_sync with its two MSBs inverted and the remaining bits equal.
REQ-025 SHALL convert rd_ptr_sync Gray-to-binary (rbin) combinationally and register level = wbin_next - rbin, modulo 2^(ADDR_W+1).
REQ-026 SHALL register almost_full = (level_next >= AFULL_TH).
REQ-027 SHALL increment stall_cnt when req!=0 and gnt=0, saturating at 255 with no wrap.
REQ-028 SHALL deassert full on the first edge after rd_ptr_sync advances; one cycle of synchroniser-induced pessimism is acceptable.
REQ-029 SHALL never accept a write while full=1; with full=1, wbin and wr_ptr_gray SHALL hold regardless of req.
REQ-030 SHALL handle simultaneous read-pointer advance and write by computing full and level from the post-write pointer and the current rd_ptr_sync.

Reset
REQ-031 SHALL, with rst_n=0 asynchronously, force gnt=0, and set wbin, rr, wr_ptr_gray, mem_we, mem_addr, mem_wdata, level, stall_cnt, full and almost_full all to 0.
REQ-032 SHALL discard any in-flight grant when reset asserts mid-transfer; no write SHALL be issued in the cycle after release.

Verification
REQ-033 Scenario: reset, req=4'b1111, rd_ptr_sync=0 -> grants 0,1,2,3,0,1,2,3 over 8 cycles; then full=1, level=8, wr_ptr_gray=4'b1100, gnt=0.
REQ-034 Scenario: full, then rd_ptr_sync=4'b0001 -> full=0 on the next edge, one grant issued, full=1 again with level=8.
REQ-035 Scenario: req=4'b0101 held with rr=0 -> gnt sequence 0001, 0100, 0001; mem_wdata matches the granted din slice each cycle.
REQ-036 Scenario: 16 writes with matching reads (rd_ptr_sync tracking) -> mem_addr wraps 7->0, wr_ptr_gray changes one bit per write, and full is never asserted.
REQ-037 Scenario: full held with req!=0 for 300 cycles -> stall_cnt=255 and saturated; wbin unchanged.
REQ-038 Scenario: rst_n pulsed low mid-burst at level=5 -> all outputs 0 immediately, and no mem_we in the first cycle after release.
